// File: rtl/rcpu_bus_pkg.sv
// Shared definitions for the RCPU memory bus unit: FSM encoding, default
// stack segment and statistics counter widths.
package rcpu_bus_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } bus_state_t;

    localparam logic [15:0] STACK_SEG_DEFAULT = 16'hD000;

    localparam int STAT_WAIT_W = 16;
    localparam int STAT_TMO_W  = 8;
    localparam int TMO_CNT_W   = 16;

endpackage

// File: rtl/rcpu_bus_timeout.sv
// Per-beat wait counter; expired is raised on the wait cycle that reaches TIMEOUT.
module rcpu_bus_timeout
    import rcpu_bus_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [TMO_CNT_W-1:0] count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + TMO_CNT_W'(1);
        end
    end

    assign expired = en && (count == TMO_CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/rcpu_bus_unit.sv
// Registered request/response bus unit between the RCPU core and memory.
// Optional wait/timeout statistics are enabled with `define RCPU_BUS_STATS_EN.
module rcpu_bus_unit
    import rcpu_bus_pkg::*;
#(
    parameter int             M         = 16,
    parameter int             N         = 32,
    parameter logic [N-M-1:0] STACK_SEG = STACK_SEG_DEFAULT,
    parameter int             TIMEOUT   = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic                   req_wide,
    input  logic                   req_stack,
    input  logic [N-1:0]           req_addr,
    input  logic [2*M-1:0]         req_wdata,
    output logic                   rsp_valid,
    output logic [2*M-1:0]         rsp_rdata,
    output logic                   rsp_err,
    output logic                   busy,
    output logic [N-1:0]           memAddr,
    output logic [M-1:0]           memWrite,
    input  logic [M-1:0]           memRead,
    output logic                   memRE,
    output logic                   memWE,
    input  logic                   memReady,
    output logic [STAT_WAIT_W-1:0] stat_wait,
    output logic [STAT_TMO_W-1:0]  stat_tmo
);

    bus_state_t     state, state_next;
    logic           wr_q, wide_q, stack_q;
    logic [2*M-1:0] wdata_q;
    logic           accept, in_beat, waiting, tmo_hit, abort;
    logic [N-1:0]   eff_addr, next_addr;

    assign accept   = req_valid && req_ready;
    assign in_beat  = (state == BEAT0) || (state == BEAT1);
    assign waiting  = in_beat && !memReady;
    assign busy     = (state != IDLE);
    assign eff_addr = req_stack ? {STACK_SEG, req_addr[M-1:0]} : req_addr;

    // Stack requests keep their segment and wrap inside the low M bits.
    assign next_addr = stack_q ? {memAddr[N-1:M], memAddr[M-1:0] + M'(1)}
                               : memAddr + N'(1);

    rcpu_bus_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst     (rst),
        .clr     (!waiting),
        .en      (waiting),
        .expired (tmo_hit)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    always_comb begin
        state_next = state;
        abort      = 1'b0;
        unique case (state)
            IDLE:  if (accept) state_next = BEAT0;
            BEAT0: begin
                if (tmo_hit) begin
                    state_next = RESP;
                    abort      = 1'b1;
                end else if (memReady) begin
                    state_next = wide_q ? BEAT1 : RESP;
                end
            end
            BEAT1: begin
                if (tmo_hit) begin
                    state_next = RESP;
                    abort      = 1'b1;
                end else if (memReady) begin
                    state_next = RESP;
                end
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            memAddr   <= '0;
            memWrite  <= '0;
            memRE     <= 1'b0;
            memWE     <= 1'b0;
            wr_q      <= 1'b0;
            wide_q    <= 1'b0;
            stack_q   <= 1'b0;
            wdata_q   <= '0;
        end else begin
            req_ready <= (state_next == IDLE);
            rsp_valid <= (state_next == RESP);
            rsp_err   <= abort;
            if (accept) begin
                wr_q                 <= req_write;
                wide_q               <= req_wide;
                stack_q              <= req_stack;
                wdata_q              <= req_wdata;
                memAddr              <= eff_addr;
                memWrite             <= req_wdata[M-1:0];
                memRE                <= !req_write;
                memWE                <= req_write;
                rsp_rdata[2*M-1:M]   <= '0;
            end
            if (state == BEAT0 && memReady) begin
                if (!wr_q) rsp_rdata[M-1:0] <= memRead;
                if (wide_q) begin
                    memAddr  <= next_addr;
                    memWrite <= wdata_q[2*M-1:M];
                end
            end
            if (state == BEAT1 && memReady && !wr_q) begin
                rsp_rdata[2*M-1:M] <= memRead;
            end
            if (state_next == RESP) begin
                memRE <= 1'b0;
                memWE <= 1'b0;
            end
        end
    end

`ifdef RCPU_BUS_STATS_EN
    logic [STAT_WAIT_W-1:0] wait_q;
    logic [STAT_TMO_W-1:0]  tmo_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q <= '0;
            tmo_q  <= '0;
        end else begin
            if (waiting && wait_q != '1) wait_q <= wait_q + STAT_WAIT_W'(1);
            if (abort && tmo_q != '1)    tmo_q  <= tmo_q + STAT_TMO_W'(1);
        end
    end

    assign stat_wait = wait_q;
    assign stat_tmo  = tmo_q;
`else
    assign stat_wait = '0;
    assign stat_tmo  = '0;
`endif

endmodule

// File: doc/rcpu_bus_unit.md
Name: rcpu_bus_unit

Overview:
- Parametrised memory bus interface that sits between the RCPU core datapath and system memory.
- Replaces the core's combinational address/write-data muxing and its implicit stall with a registered request/response handshake.
- Adds wait-state handling, split two-beat 2M-bit transfers, stack-segment addressing and a per-beat timeout with error reporting.

Parameters:
- M, 16, data word width.
- N, 32, address width; must satisfy N > M.
- STACK_SEG, 16'hD000, upper N-M address bits applied to stack-relative requests.
- TIMEOUT, 255, maximum wait cycles per beat before abort; range 1..65535.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  core request strobe
- req_ready  out  1  unit idle; request accepted when req_valid && req_ready
- req_write  in  1  1 = write, 0 = read
- req_wide  in  1  1 = two-beat 2M-bit transfer
- req_stack  in  1  1 = address is {STACK_SEG, req_addr[M-1:0]}
- req_addr  in  N  word address
- req_wdata  in  2M  write data; low word sent in beat 0
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  2M  read data; high word is 0 for narrow reads
- rsp_err  out  1  valid with rsp_valid; a beat timed out
- busy  out  1  transaction in flight; replaces the core stall
- memAddr  out  N  memory address
- memWrite  out  M  memory write data
- memRead  in  M  memory read data
- memRE  out  1  read enable
- memWE  out  1  write enable
- memReady  in  1  memory completes the current beat this cycle
- stat_wait  out  16  wait-cycle counter (optional feature)
- stat_tmo  out  8  timeout counter (optional feature)

Behaviour:
- Single clock, synchronous active-high reset. Every output is registered unless noted.
- Reset values:
  - State IDLE.
  - req_ready=1; busy=0; rsp_valid=0; rsp_err=0.
  - rsp_rdata=0; memAddr=0; memWrite=0; memRE=0; memWE=0.
  - Stats counters=0.
- Reset asserted mid-transaction aborts immediately. No rsp_valid is produced for the aborted request.
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE:
  - req_ready=1.
  - On acceptance, latch write, wide and data; compute the effective address and go to BEAT0.
  - Clear the rsp_rdata high word.
- Effective address: req_stack ? {STACK_SEG, req_addr[M-1:0]} : req_addr.
- BEAT0:
  - Drive memAddr = effective address.
  - Drive memRE = !write and memWE = write, with memWrite = low wdata.
  - Signals stay stable while memReady=0.
  - When memReady=1, the beat completes; for reads, capture memRead into rsp_rdata[M-1:0].
  - Next state: BEAT1 if wide, else RESP.
- BEAT1:
  - Same as BEAT0, but memWrite = high wdata and read data goes to rsp_rdata[2M-1:M].
  - Address is the beat-0 address + 1. For stack requests the increment wraps in the low M bits only (0xD000FFFF -> 0xD0000000). Linear requests wrap modulo 2^N.
  - Completes to RESP.
- memRE and memWE are deasserted the cycle after the completing beat.
- Timeout:
  - A per-beat counter clears at beat entry and increments each cycle memReady=0.
  - On reaching TIMEOUT, abort to RESP with rsp_err=1 and drop any remaining beat.
  - Read data already captured is retained.
- RESP: rsp_valid=1 for exactly one cycle, req_ready=0, then IDLE.
- busy = state != IDLE (combinational).
- Latency, zero-wait: narrow accepted at cycle 0 → rsp_valid at cycle 2; wide → cycle 3. Each wait cycle adds 1.
- req_valid during a transaction is ignored; the core must hold it until req_ready.
- memReady outside BEAT0/BEAT1 is ignored.

Optional Feature:
- Macro: RCPU_BUS_STATS_EN.
- Defined:
  - stat_wait is a 16-bit counter of BEAT cycles with memReady=0, saturating at 0xFFFF.
  - stat_tmo counts timeouts, saturating at 0xFF.
  - Both are cleared by rst.
- Undefined: both ports are tied to 0 and no counter logic is synthesised.

Decomposition:
- Shared package rcpu_bus_pkg:
  - State encoding enum (IDLE=0, BEAT0=1, BEAT1=2, RESP=3).
  - STACK_SEG default constant.
  - Stats counter widths.
- One sub-module, rcpu_bus_timeout: parametrised wait counter with clear, enable and expired outputs, reused for each beat.

Test Plan:
- Narrow read, memReady always 1, req_addr=0x00012345, memRead=0xBEEF → memAddr=0x00012345 with memRE=1 at cycle 1; rsp_valid at cycle 2 with rsp_rdata=0x0000BEEF and rsp_err=0.
- Wide write with req_stack=1, req_addr=0x0000FFFF, req_wdata=0x12345678:
  - Beat 0: memAddr=0xD000FFFF, memWrite=0x5678.
  - Beat 1: memAddr=0xD0000000, memWrite=0x1234.
  - Then rsp_valid.
- Wide read, memReady low for 3 cycles on beat 1, data 0x1111 then 0x2222 → memAddr and memRE held stable throughout; rsp_rdata=0x22221111; stat_wait=3 when RCPU_BUS_STATS_EN is defined.
- TIMEOUT=4, memReady stuck at 0 → abort after 4 wait cycles; rsp_valid=1, rsp_err=1, stat_tmo=1; memRE=0 afterwards.
- rst pulsed during BEAT1 of a wide write → next cycle all outputs at reset values and no rsp_valid; a new request is then accepted normally.
- req_valid held high through RESP → exactly one transaction per acceptance, and the second is accepted only when req_ready=1.
